// File: rtl/cache_fill_sequencer_pkg.sv
// Shared types and address-field positions for the cache miss-fill path.
package cache_pkg;

  typedef enum logic [2:0] {
    FS_IDLE = 3'd0,
    FS_REQ  = 3'd1,
    FS_FILL = 3'd2,
    FS_TAG  = 3'd3,
    FS_DONE = 3'd4
  } fill_state_t;

  localparam int TAG_MSB     = 25;
  localparam int TAG_LSB     = 15;
  localparam int IDX_MSB     = 14;
  localparam int IDX_LSB     = 4;
  localparam int LINE_ADDR_W = 22;
  localparam int WAYS        = 4;
  localparam int WAY_W       = $clog2(WAYS);

endpackage

// File: rtl/cache_fill_sequencer_victim_select.sv
// Victim way source for line fills: round-robin counter by default, or an
// 8-bit free-running LFSR when CACHE_FILL_LFSR_VICTIM_EN is defined.
module cache_victim_select
  import cache_pkg::*;
(
  input  logic             main_clk,
  input  logic             main_rst,
  input  logic             advance,
  output logic [WAY_W-1:0] victim
);

`ifdef CACHE_FILL_LFSR_VICTIM_EN
  logic [7:0] lfsr_q;
  logic       unused_advance;

  // Fibonacci taps 8,6,5,4; runs every cycle so victim choice is decoupled from fill rate
  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) lfsr_q <= 8'h01;
    else          lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign unused_advance = advance;
  assign victim         = lfsr_q[WAY_W-1:0];
`else
  logic [WAY_W-1:0] rr_q;

  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst)     rr_q <= '0;
    else if (advance) rr_q <= rr_q + WAY_W'(1);
  end

  assign victim = rr_q;
`endif

endmodule

// File: rtl/cache_fill_sequencer.sv
// Miss fill sequencer: fetches a line from DRAM into the data array, then
// strobes the cache_way tag write. Victim policy set by CACHE_FILL_LFSR_VICTIM_EN.
module cache_fill_sequencer
  import cache_pkg::*;
#(
  parameter int BEATS  = 8,
  parameter int BEAT_W = 3
) (
  input  logic                   main_clk,
  input  logic                   main_rst,
  input  logic                   in_hard_fault,
  input  logic [30:0]            in_fault_address,
  output logic                   out_busy,
  output logic [WAY_W-1:0]       out_way_index,
  output logic                   out_do_write,
  output logic [30:0]            out_target_address,
  output logic                   dram_req_valid,
  input  logic                   dram_req_ready,
  output logic [LINE_ADDR_W-1:0] dram_req_addr,
  input  logic                   dram_rsp_valid,
  input  logic [15:0]            dram_rsp_data,
  output logic                   data_we,
  output logic [12+BEAT_W:0]     data_addr,
  output logic [15:0]            data_wdata,
  output logic                   out_fill_done
);

  // state | meaning
  // IDLE  | waiting for a hard fault
  // REQ   | line read request held until DRAM accepts
  // FILL  | writing returned beats into the data array
  // TAG   | one-cycle tag write strobe to cache_way
  // DONE  | fill-done pulse, victim pointer advances
  localparam logic [2:0] IDLE = FS_IDLE;
  localparam logic [2:0] REQ  = FS_REQ;
  localparam logic [2:0] FILL = FS_FILL;
  localparam logic [2:0] TAG  = FS_TAG;
  localparam logic [2:0] DONE = FS_DONE;

  logic [2:0]        state_q, state_d;
  logic [30:0]       addr_q;
  logic [WAY_W-1:0]  way_q;
  logic [BEAT_W-1:0] beat_q;
  logic [WAY_W-1:0]  victim;
  logic              beat_acc;
  logic              beat_last;

  cache_victim_select u_victim (
    .main_clk (main_clk),
    .main_rst (main_rst),
    .advance  (state_q == DONE),
    .victim   (victim)
  );

  assign beat_acc  = (state_q == FILL) && dram_rsp_valid;
  assign beat_last = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_hard_fault)             state_d = REQ;
      REQ:     if (dram_req_ready)            state_d = FILL;
      FILL:    if (beat_acc && beat_last)     state_d = TAG;
      TAG:                                    state_d = DONE;
      DONE:                                   state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      way_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      // faults raised while busy are dropped; cache_way retries the access
      if ((state_q == IDLE) && in_hard_fault) begin
        addr_q <= in_fault_address;
        way_q  <= victim;
      end
      if (beat_acc) beat_q <= beat_q + BEAT_W'(1);
    end
  end

  assign out_busy           = (state_q != IDLE);
  assign out_way_index      = way_q;
  assign out_do_write       = (state_q == TAG);
  assign out_target_address = addr_q;
  assign out_fill_done      = (state_q == DONE);
  assign dram_req_valid     = (state_q == REQ);
  assign dram_req_addr      = addr_q[TAG_MSB:IDX_LSB];
  assign data_we            = beat_acc;
  assign data_addr          = {way_q, addr_q[IDX_MSB:IDX_LSB], beat_q};
  assign data_wdata         = dram_rsp_data;

endmodule

// File: tb/tb_cache_fill_sequencer.sv
// Scoreboard bench for cache_fill_sequencer; honours CACHE_FILL_LFSR_VICTIM_EN.
module tb_cache_fill_sequencer;

  localparam int BEATS  = 8;
  localparam int BEAT_W = 3;
  localparam int DA_W   = 13 + BEAT_W;

  logic            main_clk = 1'b0;
  logic            main_rst = 1'b1;
  logic            in_hard_fault = 1'b0;
  logic [30:0]     in_fault_address = '0;
  logic            out_busy;
  logic [1:0]      out_way_index;
  logic            out_do_write;
  logic [30:0]     out_target_address;
  logic            dram_req_valid;
  logic            dram_req_ready = 1'b0;
  logic [21:0]     dram_req_addr;
  logic            dram_rsp_valid = 1'b0;
  logic [15:0]     dram_rsp_data = '0;
  logic            data_we;
  logic [DA_W-1:0] data_addr;
  logic [15:0]     data_wdata;
  logic            out_fill_done;

  cache_fill_sequencer #(.BEATS(BEATS), .BEAT_W(BEAT_W)) dut (
    .main_clk           (main_clk),
    .main_rst           (main_rst),
    .in_hard_fault      (in_hard_fault),
    .in_fault_address   (in_fault_address),
    .out_busy           (out_busy),
    .out_way_index      (out_way_index),
    .out_do_write       (out_do_write),
    .out_target_address (out_target_address),
    .dram_req_valid     (dram_req_valid),
    .dram_req_ready     (dram_req_ready),
    .dram_req_addr      (dram_req_addr),
    .dram_rsp_valid     (dram_rsp_valid),
    .dram_rsp_data      (dram_rsp_data),
    .data_we            (data_we),
    .data_addr          (data_addr),
    .data_wdata         (data_wdata),
    .out_fill_done      (out_fill_done)
  );

  always #5 main_clk = ~main_clk;

  typedef struct { logic [DA_W-1:0] a; logic [15:0] d; } wr_t;
  typedef struct { logic [1:0] w; logic [30:0] a; } tag_t;

  logic [21:0] req_q[$];
  wr_t         wr_q[$];
  tag_t        tag_q[$];
  int          done_q[$];

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int rr_model = 0;       // completed fills since reset, mod 4
  logic [7:0] lfsr_m;     // reference LFSR, advances every clock from seed 1

  always @(posedge main_clk or posedge main_rst) begin
    if (main_rst) lfsr_m <= 8'h01;
    else          lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=event expected=none", name);
  endtask

  function automatic logic [1:0] exp_victim();
`ifdef CACHE_FILL_LFSR_VICTIM_EN
    return lfsr_m[1:0];
`else
    return 2'(rr_model);
`endif
  endfunction

  // monitor: pops the scoreboard whenever the DUT presents an event
  wr_t  mon_w;
  tag_t mon_t;
  always @(negedge main_clk) begin
    if (main_rst) begin
      busy_cnt = 0;
    end else begin
      if (out_busy) busy_cnt++;
      if (dram_req_valid && dram_req_ready) begin
        if (req_q.size() == 0) unexpected("req_unexpected");
        else chk("req_addr", dram_req_addr, req_q.pop_front());
      end
      if (data_we) begin
        if (wr_q.size() == 0) unexpected("wr_unexpected");
        else begin
          mon_w = wr_q.pop_front();
          chk("wr_addr", data_addr, mon_w.a);
          chk("wr_data", data_wdata, mon_w.d);
        end
      end
      if (out_do_write) begin
        if (tag_q.size() == 0) unexpected("tag_unexpected");
        else begin
          mon_t = tag_q.pop_front();
          chk("tag_way", out_way_index, mon_t.w);
          chk("tag_addr", out_target_address, mon_t.a);
        end
      end
      if (out_fill_done) begin
        if (done_q.size() == 0) unexpected("done_unexpected");
        else chk("busy_cycles", busy_cnt, done_q.pop_front());
        busy_cnt = 0;
      end
    end
  end

  task automatic do_fill(input logic [30:0] addr, input int req_delay, input int gap,
                         input bit busy_fault, input bit ramp);
    logic [1:0]  v;
    logic [15:0] dat [BEATS];
    int          n;
    v = exp_victim();
    for (int b = 0; b < BEATS; b++) dat[b] = ramp ? 16'(16'hA000 + b) : 16'($urandom);
    req_q.push_back(addr[25:4]);
    for (int b = 0; b < BEATS; b++) wr_q.push_back('{{v, addr[14:4], BEAT_W'(b)}, dat[b]});
    tag_q.push_back('{v, addr});
    done_q.push_back(1 + req_delay + BEATS * (gap + 1) + 2);

    in_fault_address = addr;
    in_hard_fault    = 1'b1;
    @(posedge main_clk); #1;
    in_hard_fault    = 1'b0;
    in_fault_address = 31'($urandom);
    for (int i = 0; i < req_delay; i++) begin
      chk("req_hold_valid", dram_req_valid, 1);
      chk("req_hold_addr", dram_req_addr, addr[25:4]);
      @(posedge main_clk); #1;
    end
    dram_req_ready = 1'b1;
    @(posedge main_clk); #1;
    dram_req_ready = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      for (int g = 0; g < gap; g++) begin
        dram_rsp_data = 16'($urandom);
        @(posedge main_clk); #1;
      end
      in_hard_fault  = busy_fault && (b == 2);
      dram_rsp_valid = 1'b1;
      dram_rsp_data  = dat[b];
      @(posedge main_clk); #1;
      dram_rsp_valid = 1'b0;
      in_hard_fault  = 1'b0;
    end
    n = 0;
    while (out_busy && n < 20) begin
      @(posedge main_clk); #1;
      n++;
    end
    if (out_busy) unexpected("fill_timeout");
    rr_model = (rr_model + 1) % 4;
  endtask

  task automatic reset_mid_fill();
    logic [1:0]  v;
    logic [30:0] addr;
    logic [15:0] d;
    v    = exp_victim();
    addr = 31'($urandom);
    req_q.push_back(addr[25:4]);
    in_fault_address = addr;
    in_hard_fault    = 1'b1;
    @(posedge main_clk); #1;
    in_hard_fault  = 1'b0;
    dram_req_ready = 1'b1;
    @(posedge main_clk); #1;
    dram_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      d = 16'($urandom);
      wr_q.push_back('{{v, addr[14:4], BEAT_W'(b)}, d});
      dram_rsp_valid = 1'b1;
      dram_rsp_data  = d;
      @(posedge main_clk); #1;
      dram_rsp_valid = 1'b0;
    end
    #2 main_rst = 1'b1;
    #1;
    chk("rst_busy", out_busy, 0);
    chk("rst_req_valid", dram_req_valid, 0);
    chk("rst_data_we", data_we, 0);
    chk("rst_do_write", out_do_write, 0);
    chk("rst_fill_done", out_fill_done, 0);
    chk("rst_way", out_way_index, 0);
    rr_model = 0;
    repeat (2) @(posedge main_clk);
    #3 main_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge main_clk); #1;
      dram_rsp_valid = 1'b1;
      dram_rsp_data  = 16'($urandom);
    end
    @(posedge main_clk); #1;
    dram_rsp_valid = 1'b0;
  endtask

  initial begin
    #23 main_rst = 1'b0;
    #1;
    chk("init_busy", out_busy, 0);
    chk("init_req_valid", dram_req_valid, 0);
    chk("init_data_we", data_we, 0);
    chk("init_do_write", out_do_write, 0);
    chk("init_fill_done", out_fill_done, 0);
    chk("init_way", out_way_index, 0);
    chk("init_target", out_target_address, 0);
    @(posedge main_clk); #1;

    do_fill(31'h0123_4560, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) do_fill(31'($urandom), 0, 0, 1'b0, 1'b0);
    do_fill(31'($urandom), 5, 2, 1'b0, 1'b0);
    do_fill(31'($urandom), 1, 1, 1'b1, 1'b0);
    reset_mid_fill();
    do_fill(31'($urandom), 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      do_fill(31'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'b0);

    repeat (4) @(posedge main_clk);
    #1;
    chk("req_left", req_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("tag_left", tag_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
